// File: rtl/scan_sequencer.sv
// Scanline sequencer: walks a small table of transmit parameters, holds each
// set stable for a setup window, fires the transmitter and waits for completion.
module scan_sequencer #(
  parameter int DW_INPUT     = 8,
  parameter int DW_ANGLE     = 8,
  parameter int DW_POINTS    = 13,
  parameter int NUM_LINES    = 8,
  parameter int SETUP_CYCLES = 7,
  parameter int TIMEOUT      = 65535,
  localparam int AW = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_we,
  input  logic [AW-1:0]        cfg_addr,
  input  logic [DW_INPUT-1:0]  cfg_r_0,
  input  logic [DW_ANGLE-1:0]  cfg_angle,
  input  logic [DW_POINTS-1:0] cfg_num_points,
  input  logic [AW:0]          num_lines,
  input  logic                 continuous,
  input  logic                 start,
  input  logic                 abort,
  output logic [DW_INPUT-1:0]  tx_r_0,
  output logic [DW_ANGLE-1:0]  tx_angle,
  output logic [DW_POINTS-1:0] tx_num_points,
  output logic                 tx_initiate,
  input  logic                 tx_done,
  output logic                 busy,
  output logic [AW-1:0]        line_idx,
  output logic                 frame_done,
  output logic                 cfg_reject,
  output logic                 err_timeout
);

  localparam int EW      = DW_INPUT + DW_ANGLE + DW_POINTS;
  localparam int SC      = (SETUP_CYCLES < 1) ? 1 : SETUP_CYCLES;
  localparam int TO      = (TIMEOUT < 1) ? 1 : TIMEOUT;
  localparam int CNT_MAX = (SC > TO) ? SC : TO;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    FIRE,
    WAIT_DONE,
    FRAME_END
  } state_t;

  state_t          state_reg, state_next;
  logic [AW-1:0]   line_reg, line_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [AW:0]     nl_reg;
  logic            cont_reg;
  logic [EW-1:0]   tx_entry_reg;
  logic            frame_done_reg, frame_done_next;
  logic            cfg_reject_reg;
  logic            err_reg;
  logic            load_tx, capture, err_set, err_clr;
  logic            tbl_we, start_ok, last_line;
  logic [EW-1:0]   cfg_entry;
  logic [EW-1:0]   entry_rd [NUM_LINES];

  assign tbl_we    = cfg_we && (state_reg == IDLE);
  assign cfg_entry = {cfg_r_0, cfg_angle, cfg_num_points};
  assign start_ok  = (num_lines != '0) && (num_lines <= (AW + 1)'(NUM_LINES));
  assign last_line = ({1'b0, line_reg} == (nl_reg - (AW + 1)'(1)));

  // One register per table entry so the whole table clears on reset.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_LINES; gi++) begin : gen_entry
      logic [EW-1:0] entry_reg;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          entry_reg <= '0;
        end else if (tbl_we && (cfg_addr == AW'(gi))) begin
          entry_reg <= cfg_entry;
        end
      end
      assign entry_rd[gi] = entry_reg;
    end
  endgenerate

  always_comb begin
    state_next      = state_reg;
    line_next       = line_reg;
    cnt_next        = cnt_reg;
    load_tx         = 1'b0;
    capture         = 1'b0;
    frame_done_next = 1'b0;
    err_set         = 1'b0;
    err_clr         = 1'b0;
    if (abort) begin
      state_next = IDLE;
      line_next  = '0;
      cnt_next   = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            if (start_ok) begin
              state_next = SETUP;
              line_next  = '0;
              cnt_next   = '0;
              load_tx    = 1'b1;
              capture    = 1'b1;
              err_clr    = 1'b1;
            end else begin
              frame_done_next = 1'b1;
            end
          end
        end
        SETUP: begin
          if (cnt_reg == CW'(SC - 1)) begin
            state_next = FIRE;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + CW'(1);
          end
        end
        FIRE: begin
          state_next = WAIT_DONE;
          cnt_next   = '0;
        end
        WAIT_DONE: begin
          // A completion arriving on the final timeout cycle still counts.
          if (tx_done) begin
            cnt_next = '0;
            if (last_line) begin
              state_next      = FRAME_END;
              frame_done_next = 1'b1;
            end else begin
              state_next = SETUP;
              line_next  = line_reg + AW'(1);
              load_tx    = 1'b1;
            end
          end else if (cnt_reg == CW'(TO - 1)) begin
            state_next = IDLE;
            line_next  = '0;
            cnt_next   = '0;
            err_set    = 1'b1;
          end else begin
            cnt_next = cnt_reg + CW'(1);
          end
        end
        FRAME_END: begin
          line_next = '0;
          cnt_next  = '0;
          if (cont_reg) begin
            state_next = SETUP;
            load_tx    = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
        default: begin
          state_next = IDLE;
          line_next  = '0;
          cnt_next   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      line_reg       <= '0;
      cnt_reg        <= '0;
      nl_reg         <= '0;
      cont_reg       <= 1'b0;
      tx_entry_reg   <= '0;
      frame_done_reg <= 1'b0;
      cfg_reject_reg <= 1'b0;
      err_reg        <= 1'b0;
    end else begin
      state_reg      <= state_next;
      line_reg       <= line_next;
      cnt_reg        <= cnt_next;
      frame_done_reg <= frame_done_next;
      cfg_reject_reg <= cfg_we && (state_reg != IDLE);
      if (load_tx) begin
        tx_entry_reg <= entry_rd[line_next];
      end
      if (capture) begin
        nl_reg   <= num_lines;
        cont_reg <= continuous;
      end
      if (err_clr) begin
        err_reg <= 1'b0;
      end else if (err_set) begin
        err_reg <= 1'b1;
      end
    end
  end

  assign tx_r_0        = tx_entry_reg[EW-1 -: DW_INPUT];
  assign tx_angle      = tx_entry_reg[DW_POINTS +: DW_ANGLE];
  assign tx_num_points = tx_entry_reg[DW_POINTS-1:0];
  assign tx_initiate   = (state_reg == FIRE);
  assign busy          = (state_reg != IDLE);
  assign line_idx      = line_reg;
  assign frame_done    = frame_done_reg;
  assign cfg_reject    = cfg_reject_reg;
  assign err_timeout   = err_reg;

endmodule

// File: doc/scan_sequencer.md
SCAN_SEQUENCER -- requirements
Module: scan_sequencer

Interface
REQ-001 SHALL have parameter DW_INPUT, default 8, meaning width of the r_0 field.
REQ-002 SHALL have parameter DW_ANGLE, default 8, meaning width of the angle field.
REQ-003 SHALL have parameter DW_POINTS, default 13, meaning width of the num_points field.
REQ-004 SHALL have parameter NUM_LINES, default 8, meaning scanline table depth (power of 2).
REQ-005 SHALL have parameter SETUP_CYCLES, default 7, meaning cycles parameters are held stable before initiate.
REQ-006 SHALL have parameter TIMEOUT, default 65535, meaning maximum cycles to wait for tx_done.
REQ-007 SHALL use one clock and an asynchronous active-low reset; ports: clk  in  1  clock; rst_n  in  1  async active-low reset.
REQ-008 SHALL have ports: cfg_we  in  1  table write strobe; cfg_addr  in  log2(NUM_LINES)  entry index; cfg_r_0  in  DW_INPUT; cfg_angle  in  DW_ANGLE; cfg_num_points  in  DW_POINTS.
REQ-009 SHALL have ports: num_lines  in  log2(NUM_LINES)+1  lines per frame; continuous  in  1  repeat frames; start  in  1  begin frame; abort  in  1  stop immediately.
REQ-010 SHALL have ports: tx_r_0, tx_angle, tx_num_points  out  DW_INPUT/DW_ANGLE/DW_POINTS  transmitter parameters; tx_initiate  out  1  one-cycle initiate; tx_done  in  1  transmitter scanline complete.
REQ-011 SHALL have ports: busy  out  1; line_idx  out  log2(NUM_LINES)  current line; frame_done  out  1  pulse; cfg_reject  out  1  pulse; err_timeout  out  1  sticky.

Function
REQ-012 SHALL implement states IDLE, SETUP, FIRE, WAIT_DONE, FRAME_END; busy=1 in every state except IDLE.
REQ-013 IDLE: start=1 with num_lines in 1..NUM_LINES SHALL go to SETUP with line_idx=0 next cycle and clear err_timeout; num_lines=0 or >NUM_LINES SHALL pulse frame_done next cycle and remain IDLE.
REQ-014 Entering SETUP SHALL register table[line_idx] onto tx_r_0/tx_angle/tx_num_points; these outputs SHALL stay constant until the next SETUP entry.
REQ-015 SETUP SHALL last exactly SETUP_CYCLES cycles (minimum 1), then FIRE.
REQ-016 FIRE SHALL assert tx_initiate for exactly one cycle, then WAIT_DONE; tx_initiate SHALL be 0 in all other states.
REQ-017 WAIT_DONE: tx_done=1 with line_idx<num_lines-1 SHALL increment line_idx and go to SETUP; with line_idx=num_lines-1 SHALL go to FRAME_END.
REQ-018 tx_done sampled in any state other than WAIT_DONE SHALL be ignored.
REQ-019 WAIT_DONE SHALL count cycles from entry; reaching TIMEOUT without tx_done SHALL set err_timeout and go to IDLE.
REQ-020 FRAME_END SHALL assert frame_done for one cycle; next state SETUP with line_idx=0 if continuous=1, else IDLE.
REQ-021 abort=1 SHALL force IDLE on the next edge from any state with priority over all other transitions; tx_initiate SHALL not assert in the abort cycle's following cycle; frame_done SHALL not pulse.
REQ-022 start while busy SHALL be ignored.
REQ-023 cfg_we while IDLE SHALL write the entry at cfg_addr on the clock edge; cfg_we while busy SHALL not write and SHALL pulse cfg_reject next cycle.
REQ-024 num_lines and continuous SHALL be captured at start; later changes SHALL not affect the running frame.

Reset
REQ-025 rst_n=0 SHALL asynchronously force IDLE, line_idx=0, tx_*=0, tx_initiate=0, frame_done=0, cfg_reject=0, err_timeout=0, busy=0, counters=0.
REQ-026 Table contents SHALL be zero after reset.
REQ-027 Reset deasserted mid-frame SHALL restart only on a new start.

Verification
REQ-028 Load 3 entries {70,50,2990},{90,130,2650},{30,70,3600}, num_lines=3, start; tx_done 20 cycles after each initiate -> 3 initiates each 7 cycles after SETUP entry with matching tx_* values, frame_done one pulse, then IDLE.
REQ-029 continuous=1, num_lines=2 -> line_idx sequence 0,1,0,1...; frame_done after every second tx_done.
REQ-030 TIMEOUT=100, tx_done never asserted -> err_timeout=1 exactly 100 cycles after WAIT_DONE entry, busy=0 next cycle.
REQ-031 abort asserted during SETUP of line 1 -> IDLE next cycle, no further tx_initiate, no frame_done.
REQ-032 cfg_we during WAIT_DONE to addr 0 -> cfg_reject pulse; next frame transmits original entry 0.
REQ-033 rst_n low during WAIT_DONE -> all outputs 0 immediately without clock edge.
